pixel_bridge: RTL and testbench
===============================

# pixel_bridge

Memory-side responder for the watermark processor's pixel port. It serves `image_pix`/`water_pix` for the index the processor presents, detects when the processor advances `index`, and captures the finished `regout_pix` into the output framebuffer write port. A host start/done handshake bounds one full-frame capture.

## Interface
Parameters:
- `PIX_W`, 12, pixel width (4:4:4 RGB)
- `IDX_W`, 12, pixel index width
- `NUM_PIX`, 4096, pixels per frame; last index is `NUM_PIX-1`

Ports (one clock; reset asynchronous, active-low):
- `clk`  in  1  system clock, shared with the processor
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  host pulse; arms a frame capture
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the frame is captured
- `index`  in  IDX_W  processor's current pixel index
- `regout_pix`  in  PIX_W  processor's result pixel
- `image_pix`  out  PIX_W  image pixel for `index`
- `water_pix`  out  PIX_W  watermark pixel for `index`
- `src_addr`  out  IDX_W  source ROM address, shared by image and watermark ROMs
- `img_data`  in  PIX_W  image ROM data, synchronous read, 1-cycle latency
- `wm_data`  in  PIX_W  watermark ROM data, same latency
- `fb_we`  out  1  framebuffer write strobe
- `fb_addr`  out  IDX_W  framebuffer write address
- `fb_data`  out  PIX_W  framebuffer write data
- `pix_count`  out  IDX_W+1  pixels written this frame
- `skip_err`  out  1  sticky: index advanced by other than +1 (or wrap)

## Operation
- Source path: `src_addr = index` (combinational). `img_data`/`wm_data` are registered into `image_pix`/`water_pix` every cycle, in all states.
- Index tracking: `idx_q` registers `index` each cycle. An advance is `index != idx_q`.
- States:
  - IDLE: `start` -> ARMED; clear `pix_count`, `skip_err`.
  - ARMED: wait for `index == 0` -> CAPTURE. No writes.
  - CAPTURE: on advance, write `regout_pix` to `fb_addr = idx_q`. `pix_count` increments. If `index != idx_q+1` and not the wrap (`idx_q == NUM_PIX-1`, `index == 0`), set `skip_err`; the write still occurs. On the wrap advance, the write of `NUM_PIX-1` occurs -> DONE.
  - DONE: pulse `done` for one cycle -> IDLE.
- `busy` is high in ARMED and CAPTURE.
- `start` is ignored unless in IDLE.
- Advances in IDLE, ARMED, or DONE produce no write.
- Arithmetic: `idx_q+1` is computed at IDX_W+1 bits and compared zero-extended. `pix_count` saturates at `NUM_PIX`.

## Timing
- Reset values: `busy=0`, `done=0`, `fb_we=0`, `fb_addr=0`, `fb_data=0`, `image_pix=0`, `water_pix=0`, `pix_count=0`, `skip_err=0`, `idx_q=0`, state IDLE.
- Source latency: `image_pix`/`water_pix` reflect a new `index` 2 cycles after it changes (ROM + output register). The processor holds each index at least 3 cycles.
- Capture write:
  - `fb_we`/`fb_addr`/`fb_data` are registered and assert in the cycle after the advance is seen, for exactly 1 cycle.
  - `fb_data` is `regout_pix` sampled in the advance cycle.
- Start latency: `start` at cycle N gives `busy` at N+1.
- Done latency: the wrap advance at cycle N gives the final `fb_we` at N+1, `done` at N+1, and `busy` low at N+1.
- Simultaneous `start` and advance in IDLE: the state goes to ARMED and no write occurs.
- `rst_n` low mid-frame: all outputs return to reset values immediately (asynchronously). No partial write completes. The framebuffer contents are left as-is.

## Structure
- Package `pixel_pkg`: `PIX_W`, `IDX_W`, `NUM_PIX` defaults, and the state enum type (IDLE, ARMED, CAPTURE, DONE).
- One sub-module, `index_tracker`:
  - Holds `idx_q`.
  - Outputs `advance`, `wrap`, and `skip` flags.
  - The FSM, write register, and counters stay in `pixel_bridge`.

## Test plan
- Reset then idle: `img_data=0xABC` and `wm_data=0x123` at `index=5` -> `src_addr=5`; `image_pix=0xABC` and `water_pix=0x123` two cycles later; `fb_we` never asserts.
- Normal frame with `NUM_PIX=8`: `start`, then step `index` 0..7 and back to 0 with 3-cycle holds and `regout_pix=0x100+idx` -> 8 writes at addresses 0..7 with data 0x100..0x107; single-cycle `done` after address 7; `pix_count=8`; `skip_err=0`.
- Skip: in CAPTURE, jump `index` 2 -> 4 -> write to address 2 still occurs; `skip_err=1` and stays set until the next accepted `start`.
- Arming: `start` while `index=3` -> no writes until `index` returns to 0; a second `start` while `busy` changes nothing.
- Reset mid-frame: assert `rst_n=0` after 3 writes -> `busy`, `fb_we`, and `pix_count` are 0 immediately; after release the state is IDLE and a later advance causes no write.
- Same-cycle `start` and advance in IDLE -> `busy=1` next cycle, no `fb_we`.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared defaults and FSM state type for the watermark pixel bridge.
package pixel_pkg;

  localparam int unsigned PIX_W_DEF   = 12;
  localparam int unsigned IDX_W_DEF   = 12;
  localparam int unsigned NUM_PIX_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/index_tracker.sv
// Registers the processor's pixel index and flags advances, frame wraps and
// out-of-order steps relative to the previously seen index.
module index_tracker #(
  parameter int unsigned IDX_W   = 12,
  parameter int unsigned NUM_PIX = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] idx_q,
  output logic             advance,
  output logic             wrap,
  output logic             skip
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);

  logic [IDX_W-1:0] idx_d;
  logic [IDX_W:0]   idx_inc;

  // Successor is formed one bit wider so the top index never aliases to zero.
  always_comb begin
    idx_d   = index;
    idx_inc = {1'b0, idx_q} + (IDX_W+1)'(1);
    advance = (index != idx_q);
    wrap    = advance && (idx_q == LAST_IDX) && (index == '0);
    skip    = advance && !wrap && ({1'b0, index} != idx_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pixel_bridge.sv
// Pixel port responder: serves source pixels for the processor's index and
// captures each finished result pixel into the framebuffer over one frame.
module pixel_bridge
  import pixel_pkg::*;
#(
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF,
  parameter int unsigned NUM_PIX = NUM_PIX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] index,
  input  logic [PIX_W-1:0] regout_pix,
  output logic [PIX_W-1:0] image_pix,
  output logic [PIX_W-1:0] water_pix,
  output logic [IDX_W-1:0] src_addr,
  input  logic [PIX_W-1:0] img_data,
  input  logic [PIX_W-1:0] wm_data,
  output logic             fb_we,
  output logic [IDX_W-1:0] fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic [IDX_W:0]   pix_count,
  output logic             skip_err
);

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(NUM_PIX);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fb_we_q, fb_we_d;
  logic [IDX_W-1:0] fb_addr_q, fb_addr_d;
  logic [PIX_W-1:0] fb_data_q, fb_data_d;
  logic [PIX_W-1:0] image_pix_q, image_pix_d;
  logic [PIX_W-1:0] water_pix_q, water_pix_d;
  logic [IDX_W:0]   pix_count_q, pix_count_d;
  logic             skip_err_q, skip_err_d;

  logic [IDX_W-1:0] idx_q;
  logic             advance;
  logic             wrap;
  logic             skip;

  index_tracker #(
    .IDX_W   (IDX_W),
    .NUM_PIX (NUM_PIX)
  ) u_index_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .index   (index),
    .idx_q   (idx_q),
    .advance (advance),
    .wrap    (wrap),
    .skip    (skip)
  );

  // ROM address follows the processor index directly; both ROMs share it.
  assign src_addr = index;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    pix_count_d = pix_count_q;
    skip_err_d  = skip_err_q;
    image_pix_d = img_data;
    water_pix_d = wm_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ARMED;
          pix_count_d = '0;
          skip_err_d  = 1'b0;
        end
      end
      ST_ARMED: begin
        if (index == '0) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        // Each advance retires the pixel just left behind, even on a bad step.
        if (advance) begin
          fb_we_d   = 1'b1;
          fb_addr_d = idx_q;
          fb_data_d = regout_pix;
          if (pix_count_q < CNT_MAX) begin
            pix_count_d = pix_count_q + (IDX_W+1)'(1);
          end
          if (skip) begin
            skip_err_d = 1'b1;
          end
          if (wrap) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      image_pix_q <= '0;
      water_pix_q <= '0;
      pix_count_q <= '0;
      skip_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      image_pix_q <= image_pix_d;
      water_pix_q <= water_pix_d;
      pix_count_q <= pix_count_d;
      skip_err_q  <= skip_err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;
  assign image_pix = image_pix_q;
  assign water_pix = water_pix_q;
  assign pix_count = pix_count_q;
  assign skip_err  = skip_err_q;

endmodule

// File: tb/tb_pixel_bridge.sv
// Scoreboard bench for pixel_bridge with an 8-pixel frame and modelled ROMs.
module tb_pixel_bridge;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned IDX_W = 12;
  localparam int unsigned NPIX  = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] index;
  logic [PIX_W-1:0] regout_pix;
  logic [PIX_W-1:0] image_pix;
  logic [PIX_W-1:0] water_pix;
  logic [IDX_W-1:0] src_addr;
  logic [PIX_W-1:0] img_data;
  logic [PIX_W-1:0] wm_data;
  logic             fb_we;
  logic [IDX_W-1:0] fb_addr;
  logic [PIX_W-1:0] fb_data;
  logic [IDX_W:0]   pix_count;
  logic             skip_err;

  pixel_bridge #(
    .PIX_W   (PIX_W),
    .IDX_W   (IDX_W),
    .NUM_PIX (NPIX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .index      (index),
    .regout_pix (regout_pix),
    .image_pix  (image_pix),
    .water_pix  (water_pix),
    .src_addr   (src_addr),
    .img_data   (img_data),
    .wm_data    (wm_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .pix_count  (pix_count),
    .skip_err   (skip_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read source ROMs with one cycle of latency.
  logic [PIX_W-1:0] img_rom [1<<IDX_W];
  logic [PIX_W-1:0] wm_rom  [1<<IDX_W];
  always @(posedge clk) begin
    img_data <= img_rom[src_addr];
    wm_data  <= wm_rom[src_addr];
  end

  typedef struct {
    int addr;
    int data;
    bit last;
  } wr_t;

  typedef enum {M_IDLE, M_ARMED, M_CAP, M_DONE} mode_t;

  wr_t   exp_q[$];
  wr_t   mon_e;
  int    n_tests;
  int    n_fail;
  int    n_writes;
  mode_t m_mode;
  int    m_prev;
  int    m_cnt;
  bit    m_skip;
  int    ticks;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_prev = 0;
    m_cnt  = 0;
    m_skip = 1'b0;
    ticks  = 0;
    exp_q.delete();
  endtask

  // Frame-level behaviour: what the bridge should have done after the coming edge.
  task automatic model_step(input bit st, input int idx, input int rv);
    bit  adv;
    bit  wrp;
    wr_t w;
    adv = (idx != m_prev);
    case (m_mode)
      M_IDLE: begin
        if (st) begin
          m_mode = M_ARMED;
          m_cnt  = 0;
          m_skip = 1'b0;
        end
      end
      M_ARMED: begin
        if (idx == 0) m_mode = M_CAP;
      end
      M_CAP: begin
        if (adv) begin
          wrp    = (m_prev == int'(NPIX) - 1) && (idx == 0);
          w.addr = m_prev;
          w.data = rv;
          w.last = wrp;
          exp_q.push_back(w);
          if (m_cnt < int'(NPIX)) m_cnt++;
          if (!wrp && idx != m_prev + 1) m_skip = 1'b1;
          if (wrp) m_mode = M_DONE;
        end
      end
      default: m_mode = M_IDLE;
    endcase
    m_prev = idx;
  endtask

  // One clock cycle of processor/host stimulus, entered and left at a negedge.
  task automatic tick(input bit st, input int idx, input logic [PIX_W-1:0] rv);
    int older;
    older      = int'(index);
    start      = st;
    index      = IDX_W'(idx);
    regout_pix = rv;
    model_step(st, idx, int'(rv));
    #1;
    check("src_addr", int'(src_addr), idx);
    @(posedge clk);
    @(negedge clk);
    check("busy", int'(busy), int'(m_mode == M_ARMED || m_mode == M_CAP));
    check("done", int'(done), int'(m_mode == M_DONE));
    check("pix_count", int'(pix_count), m_cnt);
    check("skip_err", int'(skip_err), int'(m_skip));
    ticks++;
    if (ticks >= 2) begin
      check("image_pix", int'(image_pix), int'(img_rom[older]));
      check("water_pix", int'(water_pix), int'(wm_rom[older]));
    end
    start = 1'b0;
  endtask

  task automatic step_to(input int idx, input int hold);
    tick(1'b0, idx, PIX_W'(32'h100 + int'(index)));
    for (int h = 1; h < hold; h++) tick(1'b0, idx, PIX_W'($urandom));
  endtask

  // Write monitor: every framebuffer strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_we) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", fb_addr, fb_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", int'(fb_addr), mon_e.addr);
          check("wr_data", int'(fb_data), mon_e.data);
          check("wr_done", int'(done), int'(mon_e.last));
        end
      end else begin
        check("done_without_write", int'(done), 0);
      end
    end
  end

  initial begin
    int w0;
    int cur;
    int nxt;
    int hold;
    n_tests  = 0;
    n_fail   = 0;
    n_writes = 0;
    for (int i = 0; i < (1 << IDX_W); i++) begin
      img_rom[i] = PIX_W'($urandom);
      wm_rom[i]  = PIX_W'($urandom);
    end
    img_rom[5] = 12'hABC;
    wm_rom[5]  = 12'h123;

    rst_n      = 1'b0;
    start      = 1'b0;
    index      = '0;
    regout_pix = '0;
    model_reset();
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_image_pix", int'(image_pix), 0);
    check("rst_water_pix", int'(water_pix), 0);
    check("rst_pix_count", int'(pix_count), 0);
    check("rst_skip_err", int'(skip_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle source path: index 5 serves the ROM words two cycles on.
    for (int i = 0; i < 4; i++) tick(1'b0, 5, PIX_W'($urandom));
    check("idle_image_abc", int'(image_pix), 32'hABC);
    check("idle_water_123", int'(water_pix), 32'h123);

    // Start together with an idle advance 5->0, then a clean frame.
    w0 = n_writes;
    tick(1'b1, 0, PIX_W'($urandom));
    check("start_busy_next", int'(busy), 1);
    check("start_adv_no_write", n_writes - w0, 0);
    tick(1'b0, 0, PIX_W'($urandom));
    tick(1'b0, 0, PIX_W'($urandom));
    for (int i = 1; i < int'(NPIX); i++) step_to(i, 3);
    step_to(0, 3);
    check("frame_writes", n_writes - w0, 8);
    check("frame_pix_count", int'(pix_count), 8);
    check("frame_skip_err", int'(skip_err), 0);

    // Skip 2->4: the write still lands, the sticky flag holds through idle.
    tick(1'b1, 0, PIX_W'($urandom));
    tick(1'b0, 0, PIX_W'($urandom));
    tick(1'b0, 0, PIX_W'($urandom));
    step_to(1, 3);
    step_to(2, 3);
    step_to(4, 3);
    step_to(5, 3);
    step_to(6, 3);
    step_to(7, 3);
    step_to(0, 4);
    check("skip_sticky", int'(skip_err), 1);
    check("skip_pix_count", int'(pix_count), 7);

    // Arming away from index 0, plus a second start while busy.
    step_to(3, 3);
    w0 = n_writes;
    tick(1'b1, 3, PIX_W'($urandom));
    tick(1'b0, 3, PIX_W'($urandom));
    step_to(4, 3);
    step_to(5, 3);
    tick(1'b1, 5, PIX_W'($urandom));
    step_to(6, 3);
    step_to(7, 3);
    check("armed_no_writes", n_writes - w0, 0);
    step_to(0, 3);
    for (int i = 1; i < int'(NPIX); i++) step_to(i, 3);
    step_to(0, 3);
    check("armed_frame_writes", n_writes - w0, 8);
    check("armed_skip_clear", int'(skip_err), 0);

    // Run past the last index so the pixel counter saturates.
    tick(1'b1, 0, PIX_W'($urandom));
    tick(1'b0, 0, PIX_W'($urandom));
    for (int i = 1; i <= 9; i++) step_to(i, 3);
    step_to(0, 3);
    for (int i = 1; i < int'(NPIX); i++) step_to(i, 3);
    step_to(0, 3);
    check("sat_pix_count", int'(pix_count), int'(NPIX));

    // Reset mid-frame with a write strobe in flight.
    tick(1'b1, 0, PIX_W'($urandom));
    tick(1'b0, 0, PIX_W'($urandom));
    step_to(1, 3);
    step_to(2, 3);
    step_to(3, 3);
    index      = IDX_W'(4);
    regout_pix = PIX_W'($urandom);
    model_step(1'b0, 4, int'(regout_pix));
    @(posedge clk);
    #1;
    check("pre_rst_fb_we", int'(fb_we), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_fb_we", int'(fb_we), 0);
    check("mid_rst_pix_count", int'(pix_count), 0);
    check("mid_rst_fb_addr", int'(fb_addr), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = n_writes;
    tick(1'b0, 4, PIX_W'($urandom));
    tick(1'b0, 4, PIX_W'($urandom));
    step_to(5, 3);
    check("post_rst_no_write", n_writes - w0, 0);

    // Random processor walks with occasional jumps and stray start pulses.
    for (int s = 0; s < 150; s++) begin
      cur  = int'(index);
      nxt  = ($urandom_range(0, 9) < 8) ? (cur + 1) % int'(NPIX) : int'($urandom_range(0, NPIX + 1));
      hold = int'($urandom_range(3, 5));
      tick($urandom_range(0, 3) == 0, nxt, PIX_W'($urandom));
      for (int h = 1; h < hold; h++) tick($urandom_range(0, 7) == 0, nxt, PIX_W'($urandom));
    end

    for (int i = 0; i < 3; i++) tick(1'b0, int'(index), PIX_W'($urandom));
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
